fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences the instruction-fetch phase of the multicycle datapath.
//  - Issues the memory read at PC and waits a fixed memory latency.
//  - Writes IR, then commits PC <= PC + 4 by driving ALU srcA = PC,
//    srcB mux select = 3'b001 (constant 4) and ALU op = ADD.
//  - Sits beside the main control FSM: main FSM requests a fetch, this block
//    owns the fetch-phase mux selects and write enables until fetch_done.
// PARAMETERS
//  MEM_LAT  2   memory read latency in cycles; legal range >= 1
//  CNT_W    32  width of fetch_count
// PORTS
//  clk           in   1      system clock; all state updates on rising edge
//  reset         in   1      synchronous reset, active-high
//  fetch_req     in   1      main FSM requests a fetch; level, sampled in IDLE/DONE
//  stall         in   1      freeze: blocks fetch start and WAIT countdown
//  flush         in   1      abort an in-flight fetch (branch/exception redirect)
//  mem_wr        out  1      memory write enable; always 0 in this block
//  iord          out  1      memory address select; 0 = PC
//  alu_srca      out  1      ALU A select; 0 = PC
//  alu_srcb_sel  out  3      ALU B mux select; 3'b001 = constant 4 in LATCH, else 3'b000
//  alu_op        out  3      3'b001 = ADD in LATCH, else 3'b000
//  ir_write      out  1      IR load enable
//  pc_write      out  1      PC load enable
//  fetch_busy    out  1      1 whenever state != IDLE
//  fetch_done    out  1      one-cycle pulse, fetch committed
//  fetch_count   out  CNT_W  number of committed fetches
// BEHAVIOUR
//  - All control outputs are Moore, decoded from the registered state.
//  - Reset (sync, active-high) forces:
//    - state = IDLE, fetch_count = 0, lat_cnt = 0.
//    - All outputs = 0; alu_srcb_sel = 3'b000; alu_op = 3'b000.
//  - States and transitions:
//    - IDLE: if fetch_req & !stall -> ADDR; else stay.
//    - ADDR: 1 cycle; iord = 0, mem_wr = 0; load lat_cnt = MEM_LAT -> WAIT.
//    - WAIT: if !stall, decrement lat_cnt.
//      - When lat_cnt == 1 & !stall -> LATCH.
//      - stall holds both lat_cnt and state.
//    - LATCH: 1 cycle; assert ir_write = 1, pc_write = 1, alu_srca = 0,
//      alu_srcb_sel = 3'b001, alu_op = 3'b001; fetch_count += 1 -> DONE.
//    - DONE: fetch_done = 1.
//      - If fetch_req & !stall -> ADDR (back-to-back fetch); else -> IDLE.
//  - Latency: fetch_req high at cycle 0 (in IDLE):
//    - LATCH at cycle MEM_LAT + 2.
//    - fetch_done at cycle MEM_LAT + 3.
//  - flush:
//    - In ADDR or WAIT: next state = IDLE; no ir_write/pc_write; count unchanged.
//    - In LATCH: ignored; the commit completes.
//    - In DONE: fetch_done still pulses; next state = IDLE even if fetch_req.
//    - In IDLE: blocks the start that cycle.
//  - Priority: reset > flush > stall > fetch_req.
//  - stall has no effect in ADDR or LATCH; both are fixed single-cycle states.
//  - fetch_count wraps 2^CNT_W - 1 -> 0 with no flag.
//  - Illegal/unused state encodings -> IDLE on the next clock.
// STRUCTURE
//  - Shared include ctrl_defs.vh holds:
//    - State encodings FS_IDLE/FS_ADDR/FS_WAIT/FS_LATCH/FS_DONE.
//    - Mux select constants SELB_REG=3'b000, SELB_PC4=3'b001.
//    - ALU op constants ALUOP_NONE=3'b000, ALUOP_ADD=3'b001.
//  - One sub-module, lat_counter: loadable down-counter with hold input,
//    width = clog2(MEM_LAT+1).
// TESTING
//  1. Reset, then fetch_req pulse, MEM_LAT=2, no stall:
//     ADDR at c1, WAIT c2-c3, LATCH c4 with selb=001, aluop=001, ir/pc_write=1;
//     fetch_done at c5; fetch_count=1.
//  2. fetch_req held high for 3 fetches: DONE -> ADDR with no IDLE gap;
//     fetch_count=3; exactly 3 ir_write pulses.
//  3. stall high 4 cycles mid-WAIT: lat_cnt frozen; LATCH delayed exactly
//     4 cycles; outputs stable during stall.
//  4. flush in WAIT: next cycle IDLE; no ir_write/pc_write/fetch_done;
//     fetch_count unchanged. flush in LATCH: commit and done still occur.
//  5. Preload fetch_count = 32'hFFFF_FFFF via force, complete one fetch:
//     fetch_count = 0.
//  6. reset asserted in LATCH: next cycle IDLE, all outputs 0, fetch_count=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the state encoding, the datapath select constants and the control-word decode.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_ADDR  = 3'd1,
      FS_WAIT  = 3'd2,
      FS_LATCH = 3'd3,
      FS_DONE  = 3'd4
   } fetch_state_e;

   localparam logic [2:0] SELB_REG   = 3'b000;
   localparam logic [2:0] SELB_PC4   = 3'b001;
   localparam logic [2:0] ALUOP_NONE = 3'b000;
   localparam logic [2:0] ALUOP_ADD  = 3'b001;

   typedef struct packed {
      logic       mem_wr;
      logic       iord;
      logic       alu_srca;
      logic [2:0] alu_srcb_sel;
      logic [2:0] alu_op;
      logic       ir_write;
      logic       pc_write;
      logic       fetch_busy;
      logic       fetch_done;
   } fetch_ctl_t;

   // Moore decode of one fetch state into the full control word.
   function automatic fetch_ctl_t decode_ctl(input fetch_state_e st);
      fetch_ctl_t c;
      c.mem_wr       = 1'b0;
      c.iord         = 1'b0;
      c.alu_srca     = 1'b0;
      c.alu_srcb_sel = SELB_REG;
      c.alu_op       = ALUOP_NONE;
      c.ir_write     = 1'b0;
      c.pc_write     = 1'b0;
      c.fetch_busy   = 1'b0;
      c.fetch_done   = 1'b0;
      case (st)
         FS_IDLE: begin
            c.fetch_busy = 1'b0;
         end
         FS_ADDR, FS_WAIT: begin
            c.fetch_busy = 1'b1;
         end
         FS_LATCH: begin
            c.fetch_busy   = 1'b1;
            c.ir_write     = 1'b1;
            c.pc_write     = 1'b1;
            c.alu_srcb_sel = SELB_PC4;
            c.alu_op       = ALUOP_ADD;
         end
         FS_DONE: begin
            c.fetch_busy = 1'b1;
            c.fetch_done = 1'b1;
         end
         default: begin
            c.fetch_busy = 1'b0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fetch_ctrl_lat_counter.sv
// Loadable down-counter timing the memory read latency.
// Load wins over decrement; the count saturates at zero.
module lat_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;

   // Count register: reset, load, or decrement while enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the fetch-phase datapath selects and enables
// from request to commit, beside the main control FSM.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_req,
   input  logic             stall,
   input  logic             flush,
   output logic             mem_wr,
   output logic             iord,
   output logic             alu_srca,
   output logic [2:0]       alu_srcb_sel,
   output logic [2:0]       alu_op,
   output logic             ir_write,
   output logic             pc_write,
   output logic             fetch_busy,
   output logic             fetch_done,
   output logic [CNT_W-1:0] fetch_count
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);

   fetch_state_e     state_r;
   fetch_state_e     state_next_s;
   fetch_ctl_t       ctl_r;
   logic [CNT_W-1:0] count_r;
   logic [LAT_W-1:0] lat_cnt_s;
   logic             lat_load_s;
   logic             lat_dec_s;
   logic             lat_last_s;
   logic             start_ok_s;

   lat_counter #(
      .W(LAT_W)
   ) u_lat (
      .clk      (clk),
      .reset    (reset),
      .load     (lat_load_s),
      .dec      (lat_dec_s),
      .load_val (LAT_W'(MEM_LAT)),
      .cnt      (lat_cnt_s)
   );

   // Latency counter controls and the shared start qualifier.
   always_comb begin
      lat_load_s = 1'b0;
      lat_dec_s  = 1'b0;
      lat_last_s = 1'b0;
      start_ok_s = 1'b0;
      if (state_r == FS_ADDR) begin
         lat_load_s = 1'b1;
      end else begin
         lat_load_s = 1'b0;
      end
      if ((state_r == FS_WAIT) && !stall && !flush) begin
         lat_dec_s = 1'b1;
      end else begin
         lat_dec_s = 1'b0;
      end
      // Treat zero as last too so a corrupted count cannot strand the FSM in WAIT.
      if (lat_cnt_s <= LAT_W'(1)) begin
         lat_last_s = 1'b1;
      end else begin
         lat_last_s = 1'b0;
      end
      if (fetch_req && !stall && !flush) begin
         start_ok_s = 1'b1;
      end else begin
         start_ok_s = 1'b0;
      end
   end

   // Next-state logic; flush outranks stall, which outranks fetch_req.
   always_comb begin
      state_next_s = FS_IDLE;
      case (state_r)
         FS_IDLE: begin
            if (start_ok_s) state_next_s = FS_ADDR;
            else            state_next_s = FS_IDLE;
         end
         FS_ADDR: begin
            if (flush) state_next_s = FS_IDLE;
            else       state_next_s = FS_WAIT;
         end
         FS_WAIT: begin
            if (flush)           state_next_s = FS_IDLE;
            else if (stall)      state_next_s = FS_WAIT;
            else if (lat_last_s) state_next_s = FS_LATCH;
            else                 state_next_s = FS_WAIT;
         end
         FS_LATCH: begin
            state_next_s = FS_DONE;
         end
         FS_DONE: begin
            if (start_ok_s) state_next_s = FS_ADDR;
            else            state_next_s = FS_IDLE;
         end
         default: begin
            state_next_s = FS_IDLE;
         end
      endcase
   end

   // State, registered control word (decoded from next state) and commit counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= FS_IDLE;
         ctl_r   <= decode_ctl(FS_IDLE);
         count_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         ctl_r   <= decode_ctl(state_next_s);
         if (state_r == FS_LATCH) begin
            count_r <= count_r + CNT_W'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign mem_wr       = ctl_r.mem_wr;
   assign iord         = ctl_r.iord;
   assign alu_srca     = ctl_r.alu_srca;
   assign alu_srcb_sel = ctl_r.alu_srcb_sel;
   assign alu_op       = ctl_r.alu_op;
   assign ir_write     = ctl_r.ir_write;
   assign pc_write     = ctl_r.pc_write;
   assign fetch_busy   = ctl_r.fetch_busy;
   assign fetch_done   = ctl_r.fetch_done;
   assign fetch_count  = count_r;

endmodule
